logic_gate_pipe: RTL and testbench
==================================

Name: logic_gate_pipe

Overview:
- Parametrised, registered successor to the team's single-bit combinational NAND gate.
- Applies a selectable bitwise gate (NAND, AND, OR, NOR, XOR, XNOR, PASS, NOT) to WIDTH-bit operands.
- Uses a valid/ready stream handshake.
- Per-beat mode: one registered result per input beat.
- Accumulate mode: folds a frame of beats into one result, emitted on the frame's last beat.
- Sits between a stimulus source and downstream logic in lab datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CNT_W, 8, width of the frame beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; used only on per-beat results and the first beat of a frame.
- op  input  3  gate select: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 PASS(a), 7 NOT(a).
- mode  input  1  0 = per-beat, 1 = accumulate.
- last  input  1  final beat of a frame; ignored in mode 0.
- out_valid  output  1  result held on y.
- out_ready  input  1  downstream accepts the result.
- y  output  WIDTH  registered result.
- beat_cnt  output  CNT_W  beats folded into y; always 1 in mode 0.
- cnt_ovf  output  1  beat_cnt saturated during this frame.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: out_valid=0, y=0, beat_cnt=0, cnt_ovf=0, accumulator=0, frame state=IDLE.
- A reset asserted mid-frame discards the frame and any pending result.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - The output transfers when out_valid && out_ready.
  - Transfer and acceptance in the same cycle are legal and give full throughput.
- Output stability: while out_valid=1 and out_ready=0, y, beat_cnt and cnt_ovf hold stable.
- f(x,z) is the bitwise gate selected by op; PASS and NOT ignore z.
- Frame state machine:
  - IDLE, accepted beat, mode=0: y <= f(a,b), beat_cnt <= 1, cnt_ovf <= 0, out_valid <= 1. Latency is 1 cycle. State stays IDLE.
  - IDLE, accepted beat, mode=1, last=1: same as mode 0; a single-beat frame.
  - IDLE, accepted beat, mode=1, last=0: acc <= f(a,b), cnt <= 1; op and mode latched; go to ACCUM. No output.
  - ACCUM, accepted beat, last=0: acc <= f(acc,a), cnt <= cnt+1 (saturating).
  - ACCUM, accepted beat, last=1: y <= f(acc,a), beat_cnt <= saturating cnt+1, cnt_ovf <= saturation flag, out_valid <= 1; go to IDLE.
- While in ACCUM, the latched op and mode are used; the op and mode inputs are ignored.
- out_valid clears on transfer unless a new result is produced in the same cycle.
- Counter saturation:
  - cnt saturates at 2^CNT_W-1 and sets the internal saturation flag.
  - The flag is presented on cnt_ovf with the frame result and clears at the start of the next frame.
- Non-accumulate beats (ACCUM with last=0) also obey in_ready, for a uniform handshake.

Decomposition:
- Package logic_gate_pkg holds:
  - op localparams OP_NAND..OP_NOT (3-bit).
  - mode localparams MODE_BEAT and MODE_ACC.
  - state encoding ST_IDLE and ST_ACCUM.
- Sub-module gate_unit: purely combinational WIDTH-bit f(x,z,op). It is instantiated once and fed with either (a,b) or (acc,a).

Test Plan:
- Reset then mode 0, op NAND, a=8'hF0, b=8'hCC, out_ready=1 -> next cycle out_valid=1, y=8'h3F, beat_cnt=1, cnt_ovf=0.
- Mode 1, op NAND, three beats: (a=FF, b=0F), (a=FF), (a=3C, last=1) -> one output only: y=8'hF3, beat_cnt=3. No out_valid before the last beat.
- Mode 1, op XOR: (a=01, b=02), (a=04, last=1) -> y=8'h07, beat_cnt=2. Changing op to AND on beat 2 has no effect.
- Mode 0 stream with out_ready=0 for 3 cycles -> in_ready=0, y held at first result, no beat lost. Then out_ready=1 -> results emerge in order at one per cycle.
- CNT_W=2, mode 1, op OR, five beats with a=01,02,04,08,10 and b=0 -> y=8'h1F, beat_cnt=3, cnt_ovf=1. The next single-beat frame gives cnt_ovf=0.
- Assert rst in ACCUM after 2 beats -> next cycle out_valid=0, y=0, beat_cnt=0. A following mode 1 frame of 2 beats gives beat_cnt=2 and no carry-over from the discarded frame.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared encodings for the registered logic-gate pipeline.
package logic_gate_pkg;

    // Gate select encodings
    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_PASS = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    // Result modes
    localparam logic MODE_BEAT = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    // Frame state encoding
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/logic_gate_pipe_gate_unit.sv
// Combinational WIDTH-bit bitwise gate f(x, z) selected by op.
module gate_unit
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] z,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] f
);

    // Decode the gate; PASS and NOT only look at x
    always_comb begin
        f = '0;
        unique case (op)
            OP_NAND: f = ~(x & z);
            OP_AND:  f = x & z;
            OP_OR:   f = x | z;
            OP_NOR:  f = ~(x | z);
            OP_XOR:  f = x ^ z;
            OP_XNOR: f = ~(x ^ z);
            OP_PASS: f = x;
            OP_NOT:  f = ~x;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered bitwise gate with valid/ready handshake and optional frame accumulation.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             cnt_ovf
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic [2:0]       op_q;

    logic             accept;
    logic [WIDTH-1:0] gate_x;
    logic [WIDTH-1:0] gate_z;
    logic [2:0]       gate_op;
    logic [WIDTH-1:0] gate_f;
    logic [CNT_W-1:0] cnt_inc;
    logic             sat_next;

    // A new result can only be produced once the output register is free or draining
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Select gate operands: first beat uses (a, b), later beats fold a into the accumulator
    always_comb begin
        gate_x  = a;
        gate_z  = b;
        gate_op = op;
        if (state_q == ST_ACCUM) begin
            gate_x  = acc_q;
            gate_z  = a;
            gate_op = op_q;
        end
    end

    // Saturating beat count; the flag records an increment attempted at the ceiling
    always_comb begin
        cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        sat_next = sat_q || (cnt_q == CntMax);
    end

    gate_unit #(
        .WIDTH (WIDTH)
    ) u_gate_unit (
        .x  (gate_x),
        .z  (gate_z),
        .op (gate_op),
        .f  (gate_f)
    );

    // Frame state machine with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            op_q      <= OP_NAND;
            out_valid <= 1'b0;
            y         <= '0;
            beat_cnt  <= '0;
            cnt_ovf   <= 1'b0;
        end else begin
            // A result produced below in the same cycle overrides this clear
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (mode == MODE_BEAT || last) begin
                            y         <= gate_f;
                            beat_cnt  <= CntOne;
                            cnt_ovf   <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            acc_q   <= gate_f;
                            cnt_q   <= CntOne;
                            sat_q   <= 1'b0;
                            op_q    <= op;
                            state_q <= ST_ACCUM;
                        end
                    end
                    // Only accumulate mode reaches here, so the latched mode is implicit
                    ST_ACCUM: begin
                        if (!last) begin
                            acc_q <= gate_f;
                            cnt_q <= cnt_inc;
                            sat_q <= sat_next;
                        end else begin
                            y         <= gate_f;
                            beat_cnt  <= cnt_inc;
                            cnt_ovf   <= sat_next;
                            out_valid <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (default and narrow-counter instances).
module tb_logic_gate_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       mode = 1'b0;
    logic       last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready1, out_valid1, cnt_ovf1;
    logic [7:0] y1, beat_cnt1;
    logic       in_ready2, out_valid2, cnt_ovf2;
    logic [7:0] y2;
    logic [1:0] beat_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_gate_pipe #(
        .WIDTH (8),
        .CNT_W (8)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .op        (op),
        .mode      (mode),
        .last      (last),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .y         (y1),
        .beat_cnt  (beat_cnt1),
        .cnt_ovf   (cnt_ovf1)
    );

    logic_gate_pipe #(
        .WIDTH (8),
        .CNT_W (2)
    ) u_dut_narrow (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .a         (a),
        .b         (b),
        .op        (op),
        .mode      (mode),
        .last      (last),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .y         (y2),
        .beat_cnt  (beat_cnt2),
        .cnt_ovf   (cnt_ovf2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted by the main instance
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                        input logic tmode, input logic tlast);
        int t = 0;
        a = ta;
        b = tb;
        op = top;
        mode = tmode;
        last = tlast;
        in_valid = 1'b1;
        while (!in_ready1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready1) check_eq("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) idle_cycle();
        check_eq("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        check_eq("rst_y", {24'd0, y1}, 32'd0);
        check_eq("rst_beat_cnt", {24'd0, beat_cnt1}, 32'd0);
        check_eq("rst_cnt_ovf", {31'd0, cnt_ovf1}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        rst = 1'b0;
        idle_cycle();

        // Per-beat NAND
        send(8'hF0, 8'hCC, 3'd0, 1'b0, 1'b0);
        check_eq("beat_valid", {31'd0, out_valid1}, 32'd1);
        check_eq("beat_y", {24'd0, y1}, 32'h3F);
        check_eq("beat_cnt", {24'd0, beat_cnt1}, 32'd1);
        check_eq("beat_ovf", {31'd0, cnt_ovf1}, 32'd0);
        idle_cycle();
        check_eq("beat_drained", {31'd0, out_valid1}, 32'd0);

        // Accumulate NAND: F0 -> 0F -> F3
        send(8'hFF, 8'h0F, 3'd0, 1'b1, 1'b0);
        check_eq("nand_no_out1", {31'd0, out_valid1}, 32'd0);
        send(8'hFF, 8'h00, 3'd0, 1'b1, 1'b0);
        check_eq("nand_no_out2", {31'd0, out_valid1}, 32'd0);
        send(8'h3C, 8'h00, 3'd0, 1'b1, 1'b1);
        check_eq("nand_valid", {31'd0, out_valid1}, 32'd1);
        check_eq("nand_y", {24'd0, y1}, 32'hF3);
        check_eq("nand_cnt", {24'd0, beat_cnt1}, 32'd3);
        idle_cycle();

        // Accumulate XOR; op changed to AND mid-frame must be ignored
        send(8'h01, 8'h02, 3'd4, 1'b1, 1'b0);
        send(8'h04, 8'h00, 3'd1, 1'b1, 1'b1);
        check_eq("xor_y", {24'd0, y1}, 32'h07);
        check_eq("xor_cnt", {24'd0, beat_cnt1}, 32'd2);
        idle_cycle();

        // Backpressure: A held, B waits, then A/B/C drain one per cycle
        out_ready = 1'b0;
        send(8'hF0, 8'hCC, 3'd0, 1'b0, 1'b0);
        a = 8'hF0; b = 8'hCC; op = 3'd1; mode = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_in_ready", {31'd0, in_ready1}, 32'd0);
            check_eq("bp_y_held", {24'd0, y1}, 32'h3F);
            check_eq("bp_valid_held", {31'd0, out_valid1}, 32'd1);
            idle_cycle();
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {31'd0, in_ready1}, 32'd1);
        idle_cycle();
        check_eq("bp_y_b", {24'd0, y1}, 32'hC0);
        check_eq("bp_valid_b", {31'd0, out_valid1}, 32'd1);
        op = 3'd2;
        idle_cycle();
        in_valid = 1'b0;
        check_eq("bp_y_c", {24'd0, y1}, 32'hFC);
        check_eq("bp_valid_c", {31'd0, out_valid1}, 32'd1);
        idle_cycle();
        check_eq("bp_drained", {31'd0, out_valid1}, 32'd0);

        // Counter saturation on the narrow instance
        send(8'h01, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h02, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h04, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h08, 8'h00, 3'd2, 1'b1, 1'b0);
        send(8'h10, 8'h00, 3'd2, 1'b1, 1'b1);
        check_eq("sat_y", {24'd0, y2}, 32'h1F);
        check_eq("sat_cnt", {30'd0, beat_cnt2}, 32'd3);
        check_eq("sat_ovf", {31'd0, cnt_ovf2}, 32'd1);
        check_eq("wide_cnt", {24'd0, beat_cnt1}, 32'd5);
        check_eq("wide_ovf", {31'd0, cnt_ovf1}, 32'd0);
        idle_cycle();
        send(8'h01, 8'h02, 3'd2, 1'b1, 1'b1);
        check_eq("single_y", {24'd0, y2}, 32'h03);
        check_eq("single_ovf", {31'd0, cnt_ovf2}, 32'd0);
        idle_cycle();
        send(8'h01, 8'h02, 3'd2, 1'b1, 1'b0);
        send(8'h40, 8'h00, 3'd2, 1'b1, 1'b1);
        check_eq("pair_y", {24'd0, y2}, 32'h43);
        check_eq("pair_cnt", {30'd0, beat_cnt2}, 32'd2);
        check_eq("pair_ovf", {31'd0, cnt_ovf2}, 32'd0);
        idle_cycle();

        // Reset mid-frame discards the partial accumulation
        send(8'hFF, 8'h0F, 3'd1, 1'b1, 1'b0);
        send(8'hF0, 8'h00, 3'd1, 1'b1, 1'b0);
        rst = 1'b1;
        idle_cycle();
        check_eq("mid_rst_valid", {31'd0, out_valid1}, 32'd0);
        check_eq("mid_rst_y", {24'd0, y1}, 32'd0);
        check_eq("mid_rst_cnt", {24'd0, beat_cnt1}, 32'd0);
        rst = 1'b0;
        idle_cycle();
        send(8'h10, 8'h20, 3'd2, 1'b1, 1'b0);
        check_eq("post_rst_no_out", {31'd0, out_valid1}, 32'd0);
        send(8'h01, 8'h00, 3'd2, 1'b1, 1'b1);
        check_eq("post_rst_valid", {31'd0, out_valid1}, 32'd1);
        check_eq("post_rst_y", {24'd0, y1}, 32'h31);
        check_eq("post_rst_cnt", {24'd0, beat_cnt1}, 32'd2);
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
